// File: rtl/mips_multicycle_cpu_pkg.sv
// Shared definitions for the multicycle MIPS core:
// opcodes, ALU ops, FSM states and decode bundle.
package mips_mc_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB_ALU,
    WB_MEM,
    TRAP
  } state_t;

  typedef struct packed {
    logic r_alu;
    logic jr;
    logic addi;
    logic andi;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic jal;
  } dec_t;

  function automatic logic [31:0] sext16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_multicycle_cpu_if.sv
// Unified instruction/data memory port with
// a req/ready handshake.
interface mips_multicycle_cpu_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/mips_multicycle_cpu_alu.sv
// Combinational ALU shared by PC increment,
// branch target and execute.
module mips_mc_alu
  import mips_mc_defs::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] y,
  output logic        zero
);

  logic [31:0] diff;
  logic        lt;

  assign diff = a + ~b + 32'd1;
  assign lt   = (a[31] != b[31]) ? a[31] : diff[31];

  always_comb begin
    y = a + b;
    unique case (op)
      ALU_SUB: y = diff;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'd0, lt};
      default: y = a + b;
    endcase
  end

  assign zero = (y == 32'd0);

endmodule

// File: rtl/mips_multicycle_cpu.sv
// Multicycle MIPS core: one memory port, external
// regfile, trap on illegal/misaligned, retire counter.
module mips_multicycle_cpu
  import mips_mc_defs::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          CNT_WIDTH  = 32,
  parameter bit          ENABLE_SLT = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mips_multicycle_cpu_if.master mem,
  output logic [4:0]           register_a1,
  output logic [4:0]           register_a2,
  output logic [4:0]           register_a3,
  output logic                 register_we3,
  output logic [31:0]          register_wd3,
  input  logic [31:0]          register_rd1,
  input  logic [31:0]          register_rd2,
  output logic [31:0]          pc,
  output logic                 retired,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic                 trap
);

  state_t      state, state_n;
  logic [31:0] ir, a_q, b_q, alu_out, mdr;
  logic [31:0] pc_n, ir_n, a_n, b_n;
  logic [31:0] alu_n, mdr_n;
  logic [31:0] alu_a, alu_b, alu_y;
  alu_op_t     alu_op, r_op;
  logic        alu_zero;
  logic        req, we, wr, retire;
  logic [31:0] addr;
  logic [31:0] imm_se;
  logic [5:0]  op, funct;
  dec_t        dec;

  assign op     = ir[31:26];
  assign funct  = ir[5:0];
  assign imm_se = sext16(ir[15:0]);

  always_comb begin
    dec = '0;
    unique case (1'b1)
      op == OP_RTYPE: begin
        dec.r_alu = (funct == FN_ADD)
                 || (funct == FN_SUB)
                 || (funct == FN_AND)
                 || (funct == FN_OR)
                 || (ENABLE_SLT
                     && funct == FN_SLT);
        dec.jr = (funct == FN_JR);
      end
      op == OP_ADDI: dec.addi = 1'b1;
      op == OP_ANDI: dec.andi = 1'b1;
      op == OP_LW:   dec.lw   = 1'b1;
      op == OP_SW:   dec.sw   = 1'b1;
      op == OP_BEQ:  dec.beq  = 1'b1;
      op == OP_BNE:  dec.bne  = 1'b1;
      op == OP_J:    dec.j    = 1'b1;
      op == OP_JAL:  dec.jal  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    r_op = ALU_ADD;
    unique case (1'b1)
      funct == FN_SUB: r_op = ALU_SUB;
      funct == FN_AND: r_op = ALU_AND;
      funct == FN_OR:  r_op = ALU_OR;
      funct == FN_SLT: r_op = ALU_SLT;
      default: ;
    endcase
  end

  mips_mc_alu u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .op   (alu_op),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    a_n     = a_q;
    b_n     = b_q;
    alu_n   = alu_out;
    mdr_n   = mdr;
    alu_a   = pc;
    alu_b   = 32'd4;
    alu_op  = ALU_ADD;
    req     = 1'b0;
    we      = 1'b0;
    addr    = pc;
    wr      = 1'b0;
    retire  = 1'b0;
    unique case (state)
      FETCH: begin
        req = 1'b1;
        if (mem.mem_ready) begin
          ir_n    = mem.mem_rdata;
          pc_n    = alu_y;
          state_n = DECODE;
        end
      end
      DECODE: begin
        a_n     = register_rd1;
        b_n     = register_rd2;
        alu_b   = {imm_se[29:0], 2'b00};
        alu_n   = alu_y;
        state_n = (|dec) ? EXEC : TRAP;
      end
      EXEC: begin
        alu_a = a_q;
        alu_b = b_q;
        unique case (1'b1)
          dec.r_alu: begin
            alu_op  = r_op;
            alu_n   = alu_y;
            state_n = WB_ALU;
          end
          dec.addi: begin
            alu_b   = imm_se;
            alu_n   = alu_y;
            state_n = WB_ALU;
          end
          dec.andi: begin
            alu_b   = {16'd0, ir[15:0]};
            alu_op  = ALU_AND;
            alu_n   = alu_y;
            state_n = WB_ALU;
          end
          dec.lw, dec.sw: begin
            alu_b   = imm_se;
            alu_n   = alu_y;
            state_n = (alu_y[1:0] != 2'b00)
                    ? TRAP : MEM;
          end
          dec.beq, dec.bne: begin
            alu_op = ALU_SUB;
            if (dec.beq == alu_zero) pc_n = alu_out;
            retire  = 1'b1;
            state_n = FETCH;
          end
          dec.j, dec.jal: begin
            pc_n    = {pc[31:28], ir[25:0], 2'b00};
            wr      = dec.jal;
            retire  = 1'b1;
            state_n = FETCH;
          end
          dec.jr: begin
            pc_n = a_q;
            if (a_q[1:0] != 2'b00) begin
              state_n = TRAP;
            end else begin
              retire  = 1'b1;
              state_n = FETCH;
            end
          end
          default: state_n = TRAP;
        endcase
      end
      MEM: begin
        req  = 1'b1;
        we   = dec.sw;
        addr = alu_out;
        if (mem.mem_ready) begin
          if (dec.sw) begin
            retire  = 1'b1;
            state_n = FETCH;
          end else begin
            mdr_n   = mem.mem_rdata;
            state_n = WB_MEM;
          end
        end
      end
      WB_ALU, WB_MEM: begin
        wr      = 1'b1;
        retire  = 1'b1;
        state_n = FETCH;
      end
      TRAP: ;
      default: state_n = TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      ir            <= '0;
      a_q           <= '0;
      b_q           <= '0;
      alu_out       <= '0;
      mdr           <= '0;
      retired_count <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      ir      <= ir_n;
      a_q     <= a_n;
      b_q     <= b_n;
      alu_out <= alu_n;
      mdr     <= mdr_n;
      if (retire)
        retired_count <= retired_count
                       + CNT_WIDTH'(1);
    end
  end

  // FETCH is the reset state, so the request is masked while reset is held
  assign mem.mem_req   = req & reset_n;
  assign mem.mem_we    = we & reset_n;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = b_q;

  assign register_a1 = ir[25:21];
  assign register_a2 = ir[20:16];

  always_comb begin
    register_a3 = ir[20:16];
    if (state == EXEC)
      register_a3 = 5'd31;
    else if (state == WB_ALU && dec.r_alu)
      register_a3 = ir[15:11];
  end

  assign register_wd3 = (state == WB_MEM) ? mdr
                      : (state == EXEC) ? pc
                      : alu_out;
  assign register_we3 = wr
                     && (register_a3 != 5'd0);
  assign retired      = retire;
  assign trap         = (state == TRAP);

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Bench for mips_multicycle_cpu: directed table,
// random ISA-model stimulus, trap and reset cases.
module tb_mips_multicycle_cpu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  register_a1, register_a2;
  logic [4:0]  register_a3;
  logic        register_we3;
  logic [31:0] register_wd3;
  logic [31:0] register_rd1, register_rd2;
  logic [31:0] pc;
  logic        retired;
  logic [31:0] retired_count;
  logic        trap;

  logic [31:0] rf  [32];
  logic [31:0] mrf [32];
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  int          nvec = 0;
  int          nfail = 0;

  mips_multicycle_cpu_if bus ();

  mips_multicycle_cpu dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem           (bus),
    .register_a1   (register_a1),
    .register_a2   (register_a2),
    .register_a3   (register_a3),
    .register_we3  (register_we3),
    .register_wd3  (register_wd3),
    .register_rd1  (register_rd1),
    .register_rd2  (register_rd2),
    .pc            (pc),
    .retired       (retired),
    .retired_count (retired_count),
    .trap          (trap)
  );

  always #5 clk = ~clk;

  assign register_rd1 = rf[register_a1];
  assign register_rd2 = rf[register_a2];

  typedef struct {
    logic [31:0] ins;
    int          fw;
    int          dw;
    logic [31:0] ld;
    int          lat;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] npc;
    logic        dacc;
    logic [31:0] daddr;
    logic        dwe;
    logic [31:0] dwd;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(
    input logic [31:0] ins, input int fw,
    input int dw, input logic [31:0] ld,
    input int lat, input logic we,
    input logic [4:0] wa, input logic [31:0] wd,
    input logic [31:0] npc, input logic dacc,
    input logic [31:0] daddr, input logic dwe,
    input logic [31:0] dwd
  );
    vec_t v;
    v.ins = ins; v.fw = fw; v.dw = dw;
    v.ld = ld; v.lat = lat; v.we = we;
    v.wa = wa; v.wd = wd; v.npc = npc;
    v.dacc = dacc; v.daddr = daddr;
    v.dwe = dwe; v.dwd = dwd;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // ISA-level reference: effect of one instruction
  function automatic vec_t model(
    input logic [31:0] ins, input int fw,
    input int dw, input logic [31:0] ld
  );
    vec_t v;
    logic [31:0] a, b, se, p4;
    logic [4:0]  rs, rt, rd;
    int          base;
    rs = ins[25:21]; rt = ins[20:16];
    rd = ins[15:11];
    a = mrf[rs]; b = mrf[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    p4 = exp_pc + 32'd4;
    v = mk(ins, fw, dw, ld, 0, 0, 0, 0, p4,
           0, 0, 0, 0);
    base = 4;
    case (ins[31:26])
      6'h00: begin
        v.we = 1; v.wa = rd;
        case (ins[5:0])
          6'h20: v.wd = a + b;
          6'h22: v.wd = a - b;
          6'h24: v.wd = a & b;
          6'h25: v.wd = a | b;
          6'h2a: v.wd = ($signed(a) < $signed(b))
                      ? 32'd1 : 32'd0;
          default: begin
            v.we = 0; v.npc = a; base = 3;
          end
        endcase
      end
      6'h08: begin
        v.we = 1; v.wa = rt; v.wd = a + se;
      end
      6'h0c: begin
        v.we = 1; v.wa = rt;
        v.wd = a & {16'h0, ins[15:0]};
      end
      6'h23: begin
        v.dacc = 1; v.daddr = a + se;
        v.we = 1; v.wa = rt; v.wd = ld; base = 5;
      end
      6'h2b: begin
        v.dacc = 1; v.daddr = a + se;
        v.dwe = 1; v.dwd = b;
      end
      6'h04, 6'h05: begin
        base = 3;
        if ((a == b) == (ins[26] == 1'b0))
          v.npc = p4 + (se << 2);
      end
      default: begin
        base = 3;
        v.npc = {p4[31:28], ins[25:0], 2'b00};
        if (ins[26]) begin
          v.we = 1; v.wa = 5'd31; v.wd = p4;
        end
      end
    endcase
    if (v.wa == 5'd0) v.we = 0;
    v.lat = base + fw + (v.dacc ? dw : 0);
    return v;
  endfunction

  function automatic logic [31:0] gen();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] t;
    int          k;
    rs  = 5'($urandom_range(0, 31));
    rt  = 5'($urandom_range(0, 31));
    rd  = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    k   = int'($urandom_range(0, 11));
    case (k)
      0: return {6'h0, rs, rt, rd, 5'd0, 6'h20};
      1: return {6'h0, rs, rt, rd, 5'd0, 6'h22};
      2: return {6'h0, rs, rt, rd, 5'd0, 6'h24};
      3: return {6'h0, rs, rt, rd, 5'd0, 6'h25};
      4: return {6'h0, rs, rt, rd, 5'd0, 6'h2a};
      5: return {6'h08, rs, rt, imm};
      6: return {6'h0c, rs, rt, imm};
      7, 8: begin
        t = mrf[rs];
        imm[1:0] = 2'd0 - t[1:0];
        return {(k == 7) ? 6'h23 : 6'h2b,
                rs, rt, imm};
      end
      9: begin
        if ($urandom_range(0, 1) == 1) rt = rs;
        return {$urandom_range(0, 1) == 1
                ? 6'h04 : 6'h05, rs, rt, imm};
      end
      10: begin
        t = $urandom;
        return {$urandom_range(0, 1) == 1
                ? 6'h02 : 6'h03, t[25:0]};
      end
      default: begin
        for (int i = 0; i < 8; i++) begin
          t = mrf[rs];
          if (t[1:0] == 2'b00) break;
          rs = 5'($urandom_range(0, 31));
        end
        t = mrf[rs];
        if (t[1:0] != 2'b00) rs = 5'd0;
        return {6'h0, rs, 15'd0, 6'h08};
      end
    endcase
  endfunction

  task automatic run_instr(input vec_t v);
    int cyc = 0;
    int fwc = v.fw;
    int dwc = v.dw;
    bit fetched = 0, dseen = 0;
    bit retd = 0, wseen = 0;
    while (!retd && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      if (bus.mem_req) begin
        if (!fetched) begin
          if (cyc == 1) begin
            chk("fetch_addr", bus.mem_addr, exp_pc);
            chk("fetch_we", bus.mem_we, 0);
            chk("pc", pc, exp_pc);
          end
          if (fwc == 0) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = v.ins;
            fetched = 1;
          end else fwc--;
        end else begin
          if (!dseen && v.dwe)
            chk("data_wdata", bus.mem_wdata, v.dwd);
          dseen = 1;
          chk("data_addr", bus.mem_addr, v.daddr);
          chk("data_we", bus.mem_we, v.dwe);
          if (dwc == 0) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = v.ld;
          end else dwc--;
        end
      end
      #1;
      if (register_we3) begin
        wseen = 1;
        chk("wr_addr", register_a3, v.wa);
        chk("wr_data", register_wd3, v.wd);
        rf[register_a3] = register_wd3;
      end
      if (retired) begin
        retd = 1;
        chk("latency", cyc, v.lat);
      end
    end
    if (!retd) begin
      nvec++; nfail++;
      $display("FAIL retire_timeout: ins %h", v.ins);
    end
    chk("wr_seen", wseen, v.we);
    chk("data_seen", dseen, v.dacc);
    if (v.we) mrf[v.wa] = v.wd;
    exp_cnt = exp_cnt + 32'd1;
    exp_pc  = v.npc;
    @(posedge clk);
    #1;
    chk("retired_count", retired_count, exp_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    chk("rst_req", bus.mem_req, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_cnt", retired_count, 0);
    chk("rst_trap", trap, 0);
    chk("rst_we3", register_we3, 0);
    chk("rst_retired", retired, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_pc  = 32'h0;
    exp_cnt = 32'h0;
  endtask

  task automatic run_trap(input logic [31:0] ins);
    bit fetched = 0;
    bit bad_req = 0, bad_ret = 0, bad_we = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (bus.mem_req) begin
        if (!fetched) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = ins;
          fetched = 1;
        end else bad_req = 1;
      end
      #1;
      if (retired) bad_ret = 1;
      if (register_we3) bad_we = 1;
      if (c == 5) chk("trap_set", trap, 1);
    end
    chk("trap_held", trap, 1);
    chk("trap_no_req", bad_req, 0);
    chk("trap_no_retire", bad_ret, 0);
    chk("trap_no_write", bad_we, 0);
    chk("trap_cnt", retired_count, exp_cnt);
  endtask

  initial begin
    int nwait;
    bit fetched;
    logic [31:0] ins;
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0; mrf[i] = '0;
    end
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    exp_pc  = '0;
    exp_cnt = '0;

    tbl[0]  = mk(32'h20010005, 0, 0, 0, 4, 1, 1,
                 32'h5, 32'h04, 0, 0, 0, 0);
    tbl[1]  = mk(32'h20010008, 1, 0, 0, 5, 1, 1,
                 32'h8, 32'h08, 0, 0, 0, 0);
    tbl[2]  = mk(32'h8C220004, 0, 2, 32'hDEADBEEF,
                 7, 1, 2, 32'hDEADBEEF, 32'h0C,
                 1, 32'h0C, 0, 0);
    tbl[3]  = mk(32'h00221820, 0, 0, 0, 4, 1, 3,
                 32'hDEADBEF7, 32'h10, 0, 0, 0, 0);
    tbl[4]  = mk(32'h1021FFFF, 0, 0, 0, 3, 0, 0,
                 0, 32'h10, 0, 0, 0, 0);
    tbl[5]  = mk(32'h1421FFFF, 0, 0, 0, 3, 0, 0,
                 0, 32'h14, 0, 0, 0, 0);
    tbl[6]  = mk(32'hAC220008, 0, 1, 0, 5, 0, 0,
                 0, 32'h18, 1, 32'h10, 1,
                 32'hDEADBEEF);
    tbl[7]  = mk(32'h00222022, 0, 0, 0, 4, 1, 4,
                 32'h21524119, 32'h1C, 0, 0, 0, 0);
    tbl[8]  = mk(32'h0041282A, 0, 0, 0, 4, 1, 5,
                 32'h1, 32'h20, 0, 0, 0, 0);
    tbl[9]  = mk(32'h0C000040, 0, 0, 0, 3, 1, 31,
                 32'h24, 32'h100, 0, 0, 0, 0);
    tbl[10] = mk(32'h03E00008, 0, 0, 0, 3, 0, 0,
                 0, 32'h24, 0, 0, 0, 0);
    tbl[11] = mk(32'h3046F0F0, 0, 0, 0, 4, 1, 6,
                 32'hB0E0, 32'h28, 0, 0, 0, 0);
    tbl[12] = mk(32'h20200001, 2, 0, 0, 6, 0, 0,
                 0, 32'h2C, 0, 0, 0, 0);
    tbl[13] = mk(32'h00223825, 0, 0, 0, 4, 1, 7,
                 32'hDEADBEEF, 32'h30, 0, 0, 0, 0);
    tbl[14] = mk(32'h00224024, 0, 0, 0, 4, 1, 8,
                 32'h8, 32'h34, 0, 0, 0, 0);
    tbl[15] = mk(32'h08000000, 0, 0, 0, 3, 0, 0,
                 0, 32'h0, 0, 0, 0, 0);

    do_reset();
    for (int i = 0; i < 16; i++) run_instr(tbl[i]);

    for (int i = 0; i < 300; i++) begin
      ins = gen();
      run_instr(model(ins,
        int'($urandom_range(0, 2)),
        int'($urandom_range(0, 2)),
        $urandom));
    end

    do_reset();
    run_trap(32'hFC000000);

    do_reset();
    run_instr(model(32'h20010006, 0, 0, 0));
    run_trap(32'h8C220000);

    // store aborted by reset in its second wait cycle
    do_reset();
    run_instr(model(32'h20010020, 0, 0, 0));
    nwait = 0;
    fetched = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (bus.mem_req && !fetched) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hAC210000;
        fetched = 1;
      end else if (bus.mem_req && bus.mem_we) begin
        nwait++;
        if (nwait == 2) break;
      end
    end
    chk("mid_store_wait", nwait, 2);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", bus.mem_req, 0);
    chk("mid_rst_we", bus.mem_we, 0);
    chk("mid_rst_cnt", retired_count, 0);
    do_reset();
    run_instr(model(32'h20030007, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_cpu.md
Name: mips_multicycle_cpu

Overview:
Multicycle successor to the single-cycle MIPS core. One unified memory port serves both instruction and data traffic through a req/ready handshake, so the core tolerates variable memory wait states. The register file stays external with combinational read. The core adds a controlled FSM, configurable reset vector, trap on illegal or misaligned operations, and a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
CNT_WIDTH, 32, width of retired_count
ENABLE_SLT, 1, when 0, funct 101010 is illegal and traps

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
mem_req  out  1  memory request; held stable until mem_ready
mem_we  out  1  1 = store, 0 = load/fetch
mem_addr  out  32  byte address, always word-aligned when mem_req=1
mem_wdata  out  32  store data
mem_rdata  in  32  read data, valid in any cycle with mem_req&mem_ready
mem_ready  in  1  completes the request in the same cycle
register_a1, register_a2  out  5  rs, rt from the instruction register
register_a3  out  5  write register
register_we3  out  1  write enable, one-cycle pulse
register_wd3  out  32  write data
register_rd1, register_rd2  in  32  combinational read data
pc  out  32  current PC
retired  out  1  one-cycle pulse per completed instruction
retired_count  out  CNT_WIDTH  wrapping count of retired instructions
trap  out  1  sticky; core halted

Behaviour:
- Reset (asynchronous, effective immediately, including mid-request): pc=RESET_PC, state=FETCH. mem_req, mem_we, register_we3, retired, trap and retired_count are 0. All internal registers (IR, A, B, ALUOut, MDR) are 0. An aborted memory request is dropped without completion.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. When mem_ready=1: IR<=mem_rdata, pc<=pc+4, go to DECODE. Otherwise stay, with outputs unchanged.
- DECODE: A<=rd1, B<=rd2. ALUOut<=pc+(sext(imm)<<2), the branch target. Go to EXEC, or to TRAP on an illegal opcode/funct.
- EXEC, by class:
  - R-type add/sub/and/or/slt: ALUOut<=A op B, go to WB_ALU.
  - addi/andi: ALUOut<=A op imm, go to WB_ALU. addi sign-extends; andi zero-extends.
  - lw/sw: ALUOut<=A+sext(imm). If addr[1:0]!=0, go to TRAP; otherwise go to MEM.
  - beq/bne: compare A and B. If taken, pc<=ALUOut. Retire and go to FETCH.
  - j/jal: pc<={pc[31:28],IR[25:0],2'b00}. For jal, also write r31 with the old pc, which already holds PC+4. Retire and go to FETCH.
  - jr: pc<=A. If A[1:0]!=0, go to TRAP; otherwise retire and go to FETCH.
- MEM:
  - mem_req=1, mem_addr=ALUOut.
  - sw: mem_we=1, mem_wdata=B. On ready, retire and go to FETCH.
  - lw: on ready, MDR<=mem_rdata and go to WB_MEM.
- WB_ALU: write ALUOut to rd (R-type) or rt (immediate). Retire and go to FETCH.
- WB_MEM: write MDR to rt. Retire and go to FETCH.
- Writes to r0 keep register_we3=0; the instruction still retires.
- TRAP: trap=1. No requests and no writes. Only reset exits.
- Arithmetic: 32-bit, wrapping, no overflow exceptions. slt is signed. sub is A+~B+1.
- Latency with 0 wait states, counted from the FETCH cycle: R/imm 4, lw 5, sw 4, branch/jump 3 cycles.
- Each memory wait cycle adds 1 cycle to the instruction's latency.
- retired is asserted in the final cycle of each instruction, and retired_count increments in the same edge.
- retired_count wraps from 2^CNT_WIDTH-1 to 0.
- mem_req is never asserted in DECODE, EXEC or the WB states.

Decomposition:
- Package mips_mc_defs: opcode and funct constants, the ALU operation enum, the FSM state enum (FETCH, DECODE, EXEC, MEM, WB_ALU, WB_MEM, TRAP) and a sext16 function.
- Sub-module mips_mc_alu: combinational, with inputs a, b and op, and outputs y and zero. It is shared by PC increment, branch target and execute via operand muxing.

Test Plan:
1. Reset with reset_n low, then release; memory returns addi r1,r0,5 with 0 wait -> mem_addr=RESET_PC; register_we3 pulses in cycle 4 with a3=1, wd3=5; retired_count=1.
2. Program lw r2,4(r1) with r1=8 and 2 data wait cycles -> MEM holds mem_addr=12, mem_we=0 for 3 cycles; wd3 equals the returned word; total 7 cycles.
3. beq r1,r1,-1 at pc 0x10 -> next fetch address is 0x10; bne with equal operands -> next fetch is 0x14; 3 cycles each.
4. jal 0x40 at pc 0x20 -> r31 written with 0x24, next fetch at 0x100; then jr r31 -> fetch at 0x24.
5. Opcode 6'b111111, and separately lw to address 0x6 -> trap=1 and stays 1; no further mem_req; retired does not pulse.
6. Assert reset_n=0 in MEM mid-wait of a sw -> mem_req and mem_we drop immediately; after release the first request is a fetch at RESET_PC.
